// File: rtl/costas_pkg.sv
// rtl/costas_pkg.sv - shared types and constants for the BPSK dump slicer
//
// Purpose: lock FSM state encoding, accumulator guard width and the
//          error-counter width shared by bpsk_dump_slicer and costas_lock_fsm.
// Ports:   none (package).
package costas_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lock_state_t;

  // Guard bits on the integrators: 2^8 = 256 samples can never overflow.
  localparam int ACC_GUARD = 8;

  localparam int ERR_W = 16;

endpackage

// File: rtl/costas_lock_fsm.sv
// rtl/costas_lock_fsm.sv - symbol-rate lock detector with saturating error counter
//
// Purpose: tracks runs of good/bad symbols and declares/drops lock.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   sym_stb    - one pulse per completed symbol (dump cycle)
//   sym_good   - classification of that symbol, valid with sym_stb
//   locked     - high while in ST_LOCKED
//   err_count  - saturating count of bad symbols seen while locked
module costas_lock_fsm
  import costas_pkg::*;
#(
  parameter int LOCK_SYMS   = 32,
  parameter int UNLOCK_SYMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sym_stb,
  input  logic             sym_good,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_SYMS + 1);
  localparam int BW = $clog2(UNLOCK_SYMS + 1);

  lock_state_t      state, state_n;
  logic [GW-1:0]    good_cnt, good_n;
  logic [BW-1:0]    bad_cnt, bad_n;
  logic [ERR_W-1:0] err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEARCH;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      err_count <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    err_n   = err_count;
    if (sym_stb) begin
      case (state)
        ST_SEARCH: begin
          if (sym_good) begin
            good_n = GW'(1);
            // A single-symbol lock requirement skips VERIFY entirely.
            if (LOCK_SYMS <= 1) begin
              state_n = ST_LOCKED;
              bad_n   = '0;
            end else begin
              state_n = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (sym_good) begin
            good_n = good_cnt + GW'(1);
            if (good_n >= GW'(LOCK_SYMS)) begin
              state_n = ST_LOCKED;
              bad_n   = '0;
            end
          end else begin
            state_n = ST_SEARCH;
            good_n  = '0;
          end
        end
        ST_LOCKED: begin
          if (sym_good) begin
            bad_n = '0;
          end else begin
            bad_n = bad_cnt + BW'(1);
            if (err_count != {ERR_W{1'b1}}) begin
              err_n = err_count + ERR_W'(1);
            end
            if (bad_n >= BW'(UNLOCK_SYMS)) begin
              state_n = ST_SEARCH;
              bad_n   = '0;
              good_n  = '0;
            end
          end
        end
        default: begin
          state_n = ST_SEARCH;
          good_n  = '0;
          bad_n   = '0;
        end
      endcase
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: rtl/bpsk_dump_slicer.sv
// rtl/bpsk_dump_slicer.sv - integrate-and-dump BPSK bit slicer with lock detection
//
// Purpose: integrates SPS valid I/Q samples per symbol, slices the I sum to a
//          bit and classifies the symbol for the lock detector.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   din_valid     - qualifies din_i/din_q
//   din_i, din_q  - signed Costas loop-filter outputs, IW bits
//   bit_out       - decided bit (1 = non-negative I sum), held between dumps
//   bit_valid     - one-cycle strobe, one cycle after the dump sample
//   locked        - lock detector state
//   err_count     - saturating bad-symbol count while locked
module bpsk_dump_slicer
  import costas_pkg::*;
#(
  parameter int SPS         = 16,
  parameter int IW          = 28,
  parameter int LOCK_SYMS   = 32,
  parameter int UNLOCK_SYMS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic signed [IW-1:0] din_i,
  input  logic signed [IW-1:0] din_q,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 locked,
  output logic [ERR_W-1:0]     err_count
);

  localparam int AW = IW + ACC_GUARD;
  localparam int CW = $clog2(SPS);

  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [AW-1:0] sum_i, sum_q;
  logic [CW-1:0]        cnt;
  logic                 dump;
  logic [AW:0]          ext_i, ext_q, mag_i, mag_q;
  logic                 sym_good;

  // Final sums include the current sample so the dump sample is counted.
  assign sum_i = acc_i + {{ACC_GUARD{din_i[IW-1]}}, din_i};
  assign sum_q = acc_q + {{ACC_GUARD{din_q[IW-1]}}, din_q};
  assign dump  = din_valid && (cnt == CW'(SPS - 1));

  // One extra bit so the magnitude of the most negative sum is exact.
  assign ext_i = {sum_i[AW-1], sum_i};
  assign ext_q = {sum_q[AW-1], sum_q};
  assign mag_i = sum_i[AW-1] ? (~ext_i + (AW+1)'(1)) : ext_i;
  assign mag_q = sum_q[AW-1] ? (~ext_q + (AW+1)'(1)) : ext_q;

  // |I| >= 2|Q|, compared one bit wider again to hold 2|Q|.
  assign sym_good = ({1'b0, mag_i} >= {mag_q, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      bit_valid <= dump;
      if (din_valid) begin
        if (dump) begin
          acc_i   <= '0;
          acc_q   <= '0;
          cnt     <= '0;
          bit_out <= ~sum_i[AW-1];
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + CW'(1);
        end
      end
    end
  end

  costas_lock_fsm #(
    .LOCK_SYMS  (LOCK_SYMS),
    .UNLOCK_SYMS(UNLOCK_SYMS)
  ) u_lock (
    .clk      (clk),
    .rst      (rst),
    .sym_stb  (dump),
    .sym_good (sym_good),
    .locked   (locked),
    .err_count(err_count)
  );

endmodule

// File: tb/tb_bpsk_dump_slicer.sv
// tb/tb_bpsk_dump_slicer.sv - self-checking bench for bpsk_dump_slicer
module tb_bpsk_dump_slicer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b0;
  logic               va = 1'b0, vb = 1'b0;
  logic signed [27:0] ia = '0, qa = '0, ib = '0, qb = '0;
  logic               bo_a, bv_a, lk_a, bo_b, bv_b, lk_b;
  logic [15:0]        err_a, err_b;

  bpsk_dump_slicer #(.SPS(16), .IW(28), .LOCK_SYMS(4), .UNLOCK_SYMS(2)) dut_a (
    .clk(clk), .rst(rst), .din_valid(va), .din_i(ia), .din_q(qa),
    .bit_out(bo_a), .bit_valid(bv_a), .locked(lk_a), .err_count(err_a)
  );

  bpsk_dump_slicer #(.SPS(256), .IW(28), .LOCK_SYMS(2), .UNLOCK_SYMS(8)) dut_b (
    .clk(clk), .rst(rst), .din_valid(vb), .din_i(ib), .din_q(qb),
    .bit_out(bo_b), .bit_valid(bv_b), .locked(lk_b), .err_count(err_b)
  );

  int errors = 0;
  int checks = 0;
  int pulses_a = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: symbol sums in plain integers, lock rules as counts.
  localparam int M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;
  int     p_sps[2]    = '{16, 256};
  int     p_lock[2]   = '{4, 2};
  int     p_unlock[2] = '{2, 8};
  longint m_si[2], m_sq[2];
  int     m_n[2], m_st[2], m_gc[2], m_bc[2], m_err[2];
  bit     m_bit[2], m_bv[2];

  function automatic longint labs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset(input int k);
    m_si[k] = 0; m_sq[k] = 0; m_n[k] = 0;
    m_st[k] = M_SEARCH; m_gc[k] = 0; m_bc[k] = 0; m_err[k] = 0;
    m_bit[k] = 0; m_bv[k] = 0;
  endtask

  task automatic model_symbol(input int k, input bit good);
    if (m_st[k] == M_SEARCH) begin
      if (good) begin
        m_gc[k] = 1;
        m_st[k] = (m_gc[k] >= p_lock[k]) ? M_LOCKED : M_VERIFY;
        m_bc[k] = 0;
      end
    end else if (m_st[k] == M_VERIFY) begin
      if (good) begin
        m_gc[k]++;
        if (m_gc[k] >= p_lock[k]) begin
          m_st[k] = M_LOCKED;
          m_bc[k] = 0;
        end
      end else begin
        m_st[k] = M_SEARCH;
        m_gc[k] = 0;
      end
    end else begin
      if (good) m_bc[k] = 0;
      else begin
        m_bc[k]++;
        if (m_err[k] < 65535) m_err[k]++;
        if (m_bc[k] >= p_unlock[k]) begin
          m_st[k] = M_SEARCH;
          m_bc[k] = 0;
          m_gc[k] = 0;
        end
      end
    end
  endtask

  task automatic model_sample(input int k, input bit v, input longint i, input longint q);
    m_bv[k] = 0;
    if (v) begin
      m_si[k] += i;
      m_sq[k] += q;
      m_n[k]++;
      if (m_n[k] == p_sps[k]) begin
        m_bit[k] = (m_si[k] >= 0);
        m_bv[k]  = 1;
        model_symbol(k, labs(m_si[k]) >= 2 * labs(m_sq[k]));
        m_si[k] = 0; m_sq[k] = 0; m_n[k] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("A.bit_valid", bv_a, m_bv[0]);
    check("A.bit_out", bo_a, m_bit[0]);
    check("A.locked", lk_a, m_st[0] == M_LOCKED);
    check("A.err_count", err_a, m_err[0]);
    check("B.bit_valid", bv_b, m_bv[1]);
    check("B.bit_out", bo_b, m_bit[1]);
    check("B.locked", lk_b, m_st[1] == M_LOCKED);
    check("B.err_count", err_b, m_err[1]);
  endtask

  // One clock: drive instance k (other idle), update model, check both.
  task automatic cyc(input bit r, input int k, input bit v, input longint i, input longint q);
    rst = r;
    va  = (k == 0) && v;
    vb  = (k == 1) && v;
    if (k == 0) begin ia = i[27:0]; qa = q[27:0]; end
    else begin ib = i[27:0]; qb = q[27:0]; end
    @(posedge clk);
    if (r) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_sample(k, v, i, q);
      model_sample(1 - k, 1'b0, 0, 0);
    end
    #1;
    check_outputs();
    pulses_a += int'(bv_a);
  endtask

  task automatic symbol_a(input longint i, input longint q, input int gap);
    for (int n = 0; n < 16; n++) begin
      for (int g = 0; g < gap; g++) cyc(0, 0, 0, -i, q + 7);
      cyc(0, 0, 1, i, q);
    end
  endtask

  function automatic longint r28();
    return longint'($urandom_range(32'h0FFF_FFFF, 0)) - 134217728;
  endfunction

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset with concurrent din_valid.
    for (int n = 0; n < 3; n++) cyc(1, 0, 1, 5, 5);
    check("rst.bit_out", bo_a, 0);
    check("rst.bit_valid", bv_a, 0);
    check("rst.locked", lk_a, 0);
    check("rst.err_count", err_a, 0);

    // Basic dump, contiguous then gapped (every 3rd cycle).
    symbol_a(1000, 0, 0);
    cyc(0, 0, 0, 0, 0);
    symbol_a(-1000, 0, 0);
    cyc(0, 0, 0, 0, 0);
    symbol_a(1000, 0, 2);
    symbol_a(-1000, 0, 2);
    cyc(0, 0, 0, 0, 0);

    // Lock then unlock.
    cyc(1, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) symbol_a(1000, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lock.locked_after_4", lk_a, 1);
    symbol_a(1000, 800, 0);
    check("lock.still_locked", lk_a, 1);
    symbol_a(1000, 800, 0);
    cyc(0, 0, 0, 0, 0);
    check("unlock.locked", lk_a, 0);
    check("unlock.err_count", err_a, 2);

    // Reset mid-symbol.
    for (int n = 0; n < 7; n++) cyc(0, 0, 1, -30000, 0);
    cyc(1, 0, 1, -30000, 0);
    pulses_a = 0;
    symbol_a(1000, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("midrst.pulses", pulses_a, 1);
    check("midrst.bit_out", bo_a, 1);

    // Randomized symbols with random gaps and junk on idle cycles.
    for (int s = 0; s < 60; s++) begin
      int cls;
      longint si, sq;
      cls = int'($urandom_range(9, 0));
      si  = ($urandom_range(1, 0) != 0) ? 1 : -1;
      sq  = ($urandom_range(1, 0) != 0) ? 1 : -1;
      for (int n = 0; n < 16; n++) begin
        longint i, q;
        if (cls < 7) begin
          i = si * longint'($urandom_range(60000, 40000));
          q = longint'($urandom_range(20000, 0)) - 10000;
        end else if (cls < 9) begin
          i = longint'($urandom_range(20000, 0)) - 10000;
          q = sq * longint'($urandom_range(60000, 40000));
        end else begin
          i = r28();
          q = r28();
        end
        for (int g = int'($urandom_range(2, 0)); g > 0; g--) cyc(0, 0, 0, r28(), r28());
        cyc(0, 0, 1, i, q);
      end
    end

    // Extreme values on the SPS=256 instance: |I| == 2|Q| exactly is good.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 256; n++) begin
        longint q;
        q = -67108864;
        if (s == 2 && n == 0) q = -67108865;
        cyc(0, 1, 1, -134217728, q);
      end
      cyc(0, 1, 0, 0, 0);
      check("ext.bit_out", bo_b, 0);
      if (s == 1) check("ext.locked", lk_b, 1);
    end
    check("ext.err_count", err_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
